// File: rtl/branch_pkg.sv
// branch_pkg: ex_branch encodings and BHT counter reset value shared by the pipeline, decoder and branch unit.
package branch_pkg;
    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_BEQ  = 3'b100,
        BR_BNE  = 3'b101,
        BR_LT   = 3'b110,
        BR_GE   = 3'b111
    } br_op_e;

    // weakly not-taken: MSB clear, all lower bits set
    function automatic int ctr_rst(input int w);
        return (1 << (w - 1)) - 1;
    endfunction
endpackage

// File: rtl/branch_resolve_unit_bht.sv
// bht_table: saturating-counter branch history table with a read port that bypasses a same-index write.
module bht_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic                       rd_msb,
    input  logic                       wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic                       wr_taken
);
    localparam logic [CTR_W-1:0] RST = CTR_W'(ctr_rst(CTR_W));

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [CTR_W-1:0] cur;
    logic [CTR_W-1:0] nxt;

    always_comb begin
        cur = ctr[wr_idx];
        nxt = wr_taken ? ((&cur) ? cur : cur + 1'b1) : ((|cur) ? cur - 1'b1 : cur);
    end

    assign rd_msb = (wr_en && wr_idx == rd_idx) ? nxt[CTR_W-1] : ctr[rd_idx][CTR_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= RST;
        end else if (wr_en) begin
            ctr[wr_idx] <= nxt;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolution, redirect and next-PC selects,
// BHT direction prediction for fetch, and saturating branch/mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_W       = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [2:0]       ex_branch,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             zero,
    input  logic             less,
    output logic             pc_a_src,
    output logic             pc_b_src,
    output logic             redirect,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    br_op_e op;
    logic   is_jump;
    logic   is_cond;
    logic   taken;
    logic   train;

    assign op      = br_op_e'(ex_branch);
    assign is_jump = op == BR_JAL || op == BR_JALR;
    assign is_cond = ex_branch[2];

    // undefined codes (e.g. 011) fall through to not-taken and never redirect
    assign taken = is_jump      ? 1'b1  :
                   op == BR_BEQ ? zero  :
                   op == BR_BNE ? !zero :
                   op == BR_LT  ? less  :
                   op == BR_GE  ? !less : 1'b0;

    assign pc_a_src = ex_valid & taken;
    assign pc_b_src = ex_valid & (op == BR_JALR);
    assign redirect = ex_valid & (is_jump | (is_cond & (taken != ex_pred_taken)));
    assign train    = ex_valid & !ex_stall & is_cond;

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .CTR_W   (CTR_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX+1:2]),
        .rd_msb   (pred_taken),
        .wr_en    (train),
        .wr_idx   (ex_pc[IDX+1:2]),
        .wr_taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (train) begin
            if (~&br_cnt) br_cnt <= br_cnt + 1'b1;
            if (redirect && ~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0], ex_pc[XLEN-1:IDX+2], ex_pc[1:0]};
endmodule
